// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared widths, default parameters and FIFO entry type for the
//               multiply-accumulate frame unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    localparam int OPND_W        = 4;   // operand width of num1/num2
    localparam int PROD_W        = 8;   // full unsigned product width

    localparam int FRAME_LEN_DEF = 4;
    localparam int ACC_W_DEF     = 10;
    localparam int DEPTH_DEF     = 4;

    // One completed frame as stored in the output FIFO (default widths).
    typedef struct packed {
        logic [ACC_W_DEF-1:0] sum;
        logic                 ovf;
    } mac_entry_t;

endpackage
`default_nettype wire

// File: rtl/mac_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mac_sync_fifo
// Description : Single-clock first-word-fall-through FIFO. The head entry is
//               visible whenever the FIFO is non-empty and reads as zero when
//               empty. Pointers carry one extra bit to tell full from empty.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_sync_fifo
    import mac_pkg::*;
#(
    parameter int  DEPTH = DEPTH_DEF,
    parameter type T     = mac_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    T             r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_push;
    logic         w_pop;

    // Writes into a full FIFO and reads from an empty one are ignored.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    assign count  = r_wr_ptr - r_rd_ptr;
    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign head   = empty ? T'('0) : r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; both may move in the same cycle leaving count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_frame_unit.sv
`default_nettype none
// ============================================================================
// Module      : mac_frame_unit
// Description : Back-pressured multiply-accumulate stage. Registers 4x4
//               products, sums FRAME_LEN of them per frame (modulo 2^ACC_W
//               with a sticky overflow flag) and queues frame sums in an
//               output FIFO drained over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_frame_unit
    import mac_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int DEPTH     = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OPND_W-1:0]      num1,
    input  logic [OPND_W-1:0]      num2,
    input  logic                   clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_sum,
    output logic                   out_ovf,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(FRAME_LEN);

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic             ovf;
    } entry_t;

    // Stage 1: registered product
    logic [PROD_W-1:0] r_p;
    logic              r_p_valid;
    logic              r_p_last;
    logic [CNT_W-1:0]  r_cnt;

    // Stage 2: frame accumulator
    logic [ACC_W-1:0]  r_acc;
    logic              r_ovf_sticky;

    logic              w_accept;
    logic              w_cnt_last;
    logic [ACC_W:0]    w_sum;
    logic              w_last_in_s1;
    logic              w_push;
    logic [AW+1:0]     w_occupancy;
    entry_t            w_push_data;
    entry_t            w_head;
    logic              w_empty;
    logic              w_full;
    logic [AW:0]       w_count;

    assign w_accept     = in_valid && in_ready;
    assign w_cnt_last   = (r_cnt == CNT_W'(FRAME_LEN - 1));
    assign w_last_in_s1 = r_p_valid && r_p_last;

    // A frame-closing product already in stage 1 reserves its FIFO slot so a
    // push can never land on a full FIFO.
    assign w_occupancy  = {1'b0, w_count} + {{(AW+1){1'b0}}, w_last_in_s1};
    assign in_ready     = !clr && (w_occupancy < (AW+2)'(DEPTH));

    assign w_sum        = {1'b0, r_acc} + {{(ACC_W+1-PROD_W){1'b0}}, r_p};
    assign w_push       = w_last_in_s1 && !clr && !w_full;
    assign w_push_data  = '{sum: w_sum[ACC_W-1:0], ovf: r_ovf_sticky | w_sum[ACC_W]};

    // Stage 1: capture the product and track the position within the frame.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_p       <= '0;
            r_p_valid <= 1'b0;
            r_p_last  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_p_valid <= w_accept;
            if (w_accept) begin
                r_p      <= PROD_W'(num1) * PROD_W'(num2);
                r_p_last <= w_cnt_last;
                r_cnt    <= w_cnt_last ? '0 : r_cnt + CNT_W'(1);
            end
        end
    end

    // Stage 2: accumulate, and restart the frame once its sum is queued.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_acc        <= '0;
            r_ovf_sticky <= 1'b0;
        end else if (r_p_valid) begin
            if (r_p_last) begin
                r_acc        <= '0;
                r_ovf_sticky <= 1'b0;
            end else begin
                r_acc        <= w_sum[ACC_W-1:0];
                r_ovf_sticky <= r_ovf_sticky | w_sum[ACC_W];
            end
        end
    end

    mac_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (out_ready),
        .head      (w_head),
        .empty     (w_empty),
        .full      (w_full),
        .count     (w_count)
    );

    assign out_valid  = !w_empty;
    assign out_sum    = w_head.sum;
    assign out_ovf    = w_head.ovf;
    assign fifo_count = w_count;
    assign busy       = r_p_valid || (r_cnt != '0);

endmodule
`default_nettype wire

// File: doc/mac_frame_unit.md
Name: mac_frame_unit

Overview:
- Downstream consumer of the 4x4 multiplier operand stream (num1/num2, 8-bit product).
- Accepts operand pairs over a valid/ready handshake and forms registered products.
- Accumulates FRAME_LEN products into one frame sum and queues completed sums in an output FIFO, which drains over a second valid/ready handshake.
- Gives the verification environment a sequential, back-pressured multiply-accumulate stage behind the combinational multiplier.

Parameters:
- FRAME_LEN, 4, number of products summed per frame (>=2).
- ACC_W, 10, accumulator and out_sum width in bits; sums wrap modulo 2^ACC_W.
- DEPTH, 4, output FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept a pair this cycle
- num1  in  4  unsigned operand A
- num2  in  4  unsigned operand B
- clr  in  1  synchronous clear of the partial frame
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes the head
- out_sum  out  ACC_W  frame sum at FIFO head
- out_ovf  out  1  frame at head overflowed ACC_W
- fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries
- busy  out  1  partial frame or product in flight

Behaviour:
- Reset (rst=1 at posedge) sets the following:
  - Accumulator, sample counter, stage-1 valid and FIFO pointers go to 0.
  - out_valid=0, out_sum=0, out_ovf=0, fifo_count=0, busy=0.
  - rst dominates clr and all handshakes. rst mid-frame discards both the partial frame and the FIFO contents.
- Accept: an input pair is accepted when in_valid && in_ready at a posedge.
- Stage 1: on accept, p <= num1*num2 (8-bit unsigned), p_valid <= 1 and p_last <= (sample counter == FRAME_LEN-1). The sample counter increments, wrapping to 0 after FRAME_LEN-1. When nothing is accepted, p_valid <= 0.
- Stage 2 (p_valid=1): the frame sum is sum = acc + zero-extended p, computed at ACC_W+1 bits.
  - An ovf_sticky bit is set when bit ACC_W of the sum is 1.
  - If p_last=1: push {sum[ACC_W-1:0], ovf_sticky | carry} into the FIFO, then clear acc and ovf_sticky. Otherwise acc <= sum[ACC_W-1:0].
- Latency: the acceptance edge of the last sample of a frame is edge t. out_valid=1 after edge t+1 when the FIFO was empty, i.e. 2 cycles.
- Backpressure: in_ready = !clr && (fifo_count + (p_valid && p_last) < DEPTH). This guarantees no push ever occurs into a full FIFO.
- FIFO behaviour:
  - First-word-fall-through: out_sum/out_ovf show the head whenever out_valid=1, and hold 0 when the FIFO is empty.
  - Pop occurs on out_valid && out_ready.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - out_ready while empty has no effect.
- clr (when rst=0):
  - Zeroes acc, ovf_sticky, the sample counter and p_valid; the FIFO is untouched.
  - in_ready=0 during clr, so no pair is accepted that cycle.
  - A product in stage 1 during clr is discarded and does not push, even when p_last=1.
- busy = p_valid || (sample counter != 0).
- Wrap: the sample counter and the FIFO pointers wrap modulo their range, and FIFO full/empty is distinguished by an extra pointer bit.

Decomposition:
- Shared package mac_pkg holds:
  - OPND_W=4 and PROD_W=8.
  - A typedef for the FIFO entry struct {sum, ovf}.
  - Default values for FRAME_LEN, ACC_W and DEPTH.
- One sub-module, mac_sync_fifo, is parameterised on DEPTH and the entry type. It implements FWFT and exposes count, full and empty. The accumulate path stays in mac_frame_unit.

Test Plan:
- Reset check: assert rst for 2 cycles and release. Required: out_valid=0, in_ready=1, fifo_count=0, busy=0, out_sum=0.
- Single frame: accept (3,5),(2,7),(15,15),(0,9) back-to-back with out_ready=1. Required: out_sum=254, out_ovf=0, out_valid high exactly 2 cycles after the 4th accept.
- Backpressure and ordering:
  - Stimulus: out_ready=0, frames with num1=k, num2=1 for k=1..4 (4 samples each), then keep in_valid=1 offering the first sample of a 5th frame.
  - Required: sums 4,8,12,16 and fifo_count=4. in_ready goes low once the 4th frame's last product sits in stage 1, and the 5th frame's first sample is not accepted while in_ready=0.
  - Then out_ready=1 for 1 cycle. Required: sum 4 popped, in_ready=1 next cycle, remaining order 8,12,16.
- Overflow: FRAME_LEN=8, eight pairs (15,15). Required: out_sum=1800 mod 1024=776, out_ovf=1. The next frame of (1,1)x8 gives out_sum=8, out_ovf=0.
- clr mid-frame: accept (9,9),(9,9), pulse clr, then (1,2)x4. Required: exactly one FIFO push, out_sum=8, and in_ready=0 during the clr cycle.
- Reset mid-operation: with 2 frames queued and 2 samples of a third accepted, assert rst. Required: fifo_count=0, out_valid=0, busy=0. A following clean frame (1,1)x4 yields out_sum=4.
